instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle instruction sequencer for the 16-bit simple architecture. It owns the PC and instruction register and fetches over a request/acknowledge memory bus. Each instruction is decoded by class bits [15:14], and the sequencer drives the datapath strobes (ALU select, register write, flag write, memory access) one phase at a time. It replaces free-running per-edge decode with an explicit FETCH/DECODE/EXEC/MEM/WB state machine.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- TIMEOUT_CYC, 255, bus-wait limit in cycles (used only with BUS_TIMEOUT_EN)
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  synchronous, active-high reset
- MEM_REQ  out  1  bus request, held until MEM_ACK is sampled high
- MEM_WE  out  1  1 = write (ST); valid while MEM_REQ is high
- MEM_ADDR  out  16  PC during FETCH; EA during MEM
- MEM_ACK  in  1  bus acknowledge; completes the access on the edge where it is sampled high
- MEM_RDATA  in  16  read data, valid with MEM_ACK
- EA  in  16  effective address from datapath (Rb + d)
- FLAG_Z, FLAG_S, FLAG_V  in  1 each  datapath flags
- PC  out  16  program counter
- IR  out  16  instruction register
- MDR  out  16  load data captured on MEM_ACK during an LD
- S_ALU  out  4  ALU select; 4'b1111 = no operation
- REG_WE  out  1  register-file write strobe, one cycle
- REG_WSEL  out  2  write source: 0 = ALU, 1 = MDR, 2 = sign-extended IR[7:0]
- FLAG_WE  out  1  flag-register write strobe, one cycle
- HALTED  out  1  sequencer is in HALT
- BUS_ERR  out  1  bus timeout occurred (only with BUS_TIMEOUT_EN; otherwise tied 0)

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: MEM_REQ=1, MEM_WE=0, MEM_ADDR=PC. On ACK: IR←MEM_RDATA, PC←PC+1 (wraps 16'hFFFF→0), go to DECODE.
- DECODE: one cycle with no strobes. Next state depends on the class:
  - 11 (ALU), IR[7:4]≠4'b1111: go to EXEC.
  - 11 with IR[7:4]=4'b1111: HLT, go to HALT.
  - 00 LD / 01 ST: go to MEM.
  - 10: go to EXEC.
- EXEC, ALU class: S_ALU=IR[7:4], REG_WE=1, REG_WSEL=0, FLAG_WE=1 for one cycle, then go to FETCH.
- EXEC, class 10, sub-op IR[13:11]:
  - 000 LI: REG_WE=1, REG_WSEL=2.
  - 100 B: PC←PC+sext(IR[7:0]).
  - 111: conditional branch on IR[10:8]:
    - 000 BE: taken if Z.
    - 001 BLT: taken if S^V.
    - 010 BLE: taken if Z|(S^V).
    - 011 BNE: taken if !Z.
    - Taken: PC←PC+sext(IR[7:0]). Not taken: PC unchanged.
  - Any other encoding executes as a NOP.
  - Next state is FETCH.
- MEM: MEM_REQ=1, MEM_ADDR=EA, MEM_WE=1 for ST and 0 for LD. Memory write data comes from the datapath. On ACK:
  - LD: MDR←MEM_RDATA, go to WB.
  - ST: go to FETCH.
- WB (LD only): REG_WE=1, REG_WSEL=1 for one cycle, then go to FETCH.
- HALT: absorbing state, HALTED=1, no strobes. Only RESET exits.
- Branch arithmetic: PC already holds the address of the branch plus 1. The 16-bit offset add is modulo 2^16.
- Flag sampling: flags are sampled in EXEC, so they reflect the last FLAG_WE.

## Timing
- Reset values: PC=RESET_PC, IR=0, MDR=0, S_ALU=4'b1111, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, REG_WE=0, REG_WSEL=0, FLAG_WE=0, HALTED=0, BUS_ERR=0, state=FETCH.
- All outputs are registered. S_ALU is 4'b1111 in every state except EXEC of an ALU op.
- MEM_ACK may be high in the first cycle of MEM_REQ. Minimum latencies:
  - ALU / LI / branch: 3 cycles.
  - ST: 3 cycles.
  - LD: 4 cycles.
  - Each wait cycle adds 1.
- MEM_ACK while MEM_REQ=0 is ignored.
- MEM_REQ and MEM_ADDR are stable until the ACK edge. MEM_REQ deasserts on the following cycle, or is re-asserted with a new address if the next state is FETCH. No back-to-back access to the same address is implied.
- RESET asserted mid-access: the state returns to FETCH and MEM_REQ=0 on the next edge. The abandoned transaction is dropped, and any late ACK is ignored.

## Configuration
- BUS_TIMEOUT_EN defined:
  - A wait counter runs in FETCH and MEM while ACK is low.
  - On reaching TIMEOUT_CYC: MEM_REQ←0, BUS_ERR←1 (sticky until reset), go to HALT.
- BUS_TIMEOUT_EN undefined: no counter, the sequencer waits indefinitely, and BUS_ERR is constant 0.

## Test plan
- Reset: hold RESET 2 cycles, RESET_PC=16'h0010 → PC=0010, S_ALU=F, MEM_REQ=0. First fetch has MEM_ADDR=0010.
- ALU op: mem[0]=16'hC030, zero-wait ACK → EXEC cycle at cycle 3 with S_ALU=3, REG_WE=1, FLAG_WE=1. PC=1, next fetch at address 1.
- LD with 2 wait cycles: IR=16'h0105, EA=16'h0200, MEM_RDATA=16'hBEEF → MEM_ADDR=0200 for 3 cycles, MDR=BEEF. WB has REG_WE=1, REG_WSEL=1.
- Conditional branch: at PC=5, IR=16'hBBFE (BNE, offset −2), Z=0 → PC=4. Same instruction with Z=1 → PC=6.
- HLT and wrap: PC=FFFF fetching 16'hC0F0 → PC wraps to 0, HALTED=1, no further MEM_REQ until RESET.
- BUS_TIMEOUT_EN, TIMEOUT_CYC=4, ACK never asserted → BUS_ERR=1 and HALTED=1 after the 4th wait cycle, MEM_REQ=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit simple architecture.
// Optional bus-wait timeout is enabled by defining BUS_TIMEOUT_EN.
module instr_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic        CLOCK,
    input  logic        RESET,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [15:0] MEM_ADDR,
    input  logic        MEM_ACK,
    input  logic [15:0] MEM_RDATA,
    input  logic [15:0] EA,
    input  logic        FLAG_Z,
    input  logic        FLAG_S,
    input  logic        FLAG_V,
    output logic [15:0] PC,
    output logic [15:0] IR,
    output logic [15:0] MDR,
    output logic [3:0]  S_ALU,
    output logic        REG_WE,
    output logic [1:0]  REG_WSEL,
    output logic        FLAG_WE,
    output logic        HALTED,
    output logic        BUS_ERR
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [3:0] ALU_NOP = 4'b1111;

    state_t      state, state_n;
    logic [15:0] pc_n, ir_n, mdr_n, mem_addr_n;
    logic [3:0]  s_alu_n;
    logic [1:0]  reg_wsel_n;
    logic        mem_req_n, mem_we_n, reg_we_n, flag_we_n, halted_n;

    logic        ack;
    logic [1:0]  ir_class;
    logic [2:0]  sub_op;
    logic        is_st;
    logic [15:0] br_off;
    logic        lt;
    logic        taken;
    logic        timeout;

    // An ACK only counts against an outstanding request.
    assign ack      = MEM_REQ & MEM_ACK;
    assign ir_class = IR[15:14];
    assign sub_op   = IR[13:11];
    assign is_st    = IR[14];
    assign br_off   = {{8{IR[7]}}, IR[7:0]};
    assign lt       = FLAG_S ^ FLAG_V;

    always_comb begin
        case (IR[10:8])
            3'b000:  taken = FLAG_Z;
            3'b001:  taken = lt;
            3'b010:  taken = FLAG_Z | lt;
            3'b011:  taken = ~FLAG_Z;
            default: taken = 1'b0;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int          CW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] wait_cnt;
    logic          waiting;
    logic          bus_err_q;

    assign waiting = (state == FETCH || state == MEM) && MEM_REQ && !MEM_ACK;
    assign timeout = waiting && (wait_cnt == LAST);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            wait_cnt  <= waiting ? wait_cnt + CW'(1) : '0;
            bus_err_q <= bus_err_q | timeout;
        end
    end

    assign BUS_ERR = bus_err_q;
`else
    assign timeout = 1'b0;
    // No timeout hardware: constant 0 for any non-negative limit.
    assign BUS_ERR = (TIMEOUT_CYC < 0);
`endif

    // Next state and next value of every registered output.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_n    = state;
        pc_n       = PC;
        ir_n       = IR;
        mdr_n      = MDR;
        mem_addr_n = MEM_ADDR;
        s_alu_n    = ALU_NOP;
        mem_req_n  = 1'b0;
        mem_we_n   = 1'b0;
        reg_we_n   = 1'b0;
        reg_wsel_n = 2'd0;
        flag_we_n  = 1'b0;
        halted_n   = 1'b0;

        case (state)
            FETCH: begin
                if (ack) begin
                    ir_n    = MEM_RDATA;
                    pc_n    = PC + 16'd1;
                    state_n = DECODE;
                end else begin
                    mem_req_n  = 1'b1;
                    mem_addr_n = PC;
                end
            end
            DECODE: begin
                case (ir_class)
                    2'b11: begin
                        if (IR[7:4] == ALU_NOP) begin
                            state_n  = HALT;
                            halted_n = 1'b1;
                        end else begin
                            state_n   = EXEC;
                            s_alu_n   = IR[7:4];
                            reg_we_n  = 1'b1;
                            flag_we_n = 1'b1;
                        end
                    end
                    2'b10: begin
                        state_n = EXEC;
                        if (sub_op == 3'b000) begin
                            reg_we_n   = 1'b1;
                            reg_wsel_n = 2'd2;
                        end
                    end
                    default: begin
                        state_n    = MEM;
                        mem_req_n  = 1'b1;
                        mem_we_n   = is_st;
                        mem_addr_n = EA;
                    end
                endcase
            end
            EXEC: begin
                // Flags are sampled here, after any preceding FLAG_WE has landed.
                if (ir_class == 2'b10 &&
                    (sub_op == 3'b100 || (sub_op == 3'b111 && taken)))
                    pc_n = PC + br_off;
                state_n    = FETCH;
                mem_req_n  = 1'b1;
                mem_addr_n = pc_n;
            end
            MEM: begin
                if (ack) begin
                    if (is_st) begin
                        state_n    = FETCH;
                        mem_req_n  = 1'b1;
                        mem_addr_n = PC;
                    end else begin
                        mdr_n      = MEM_RDATA;
                        state_n    = WB;
                        reg_we_n   = 1'b1;
                        reg_wsel_n = 2'd1;
                    end
                end else begin
                    mem_req_n = 1'b1;
                    mem_we_n  = MEM_WE;
                end
            end
            WB: begin
                state_n    = FETCH;
                mem_req_n  = 1'b1;
                mem_addr_n = PC;
            end
            default: begin
                halted_n = 1'b1;
            end
        endcase

        if (timeout) begin
            state_n   = HALT;
            mem_req_n = 1'b0;
            mem_we_n  = 1'b0;
            halted_n  = 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state    <= FETCH;
            PC       <= RESET_PC;
            IR       <= '0;
            MDR      <= '0;
            MEM_ADDR <= '0;
            S_ALU    <= ALU_NOP;
            MEM_REQ  <= 1'b0;
            MEM_WE   <= 1'b0;
            REG_WE   <= 1'b0;
            REG_WSEL <= 2'd0;
            FLAG_WE  <= 1'b0;
            HALTED   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            state    <= state_n;
            PC       <= pc_n;
            IR       <= ir_n;
            MDR      <= mdr_n;
            MEM_ADDR <= mem_addr_n;
            S_ALU    <= s_alu_n;
            MEM_REQ  <= mem_req_n;
            MEM_WE   <= mem_we_n;
            REG_WE   <= reg_we_n;
            REG_WSEL <= reg_wsel_n;
            FLAG_WE  <= flag_we_n;
            HALTED   <= halted_n;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: instructions are fed by hand over the bus
// with hand-computed PC, strobe and bus expectations.
module tb_instr_sequencer;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        MEM_REQ, MEM_WE;
    logic [15:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [15:0] MEM_RDATA, EA;
    logic        FLAG_Z, FLAG_S, FLAG_V;
    logic [15:0] PC, IR, MDR;
    logic [3:0]  S_ALU;
    logic        REG_WE;
    logic [1:0]  REG_WSEL;
    logic        FLAG_WE, HALTED, BUS_ERR;

    int total = 0;
    int bad   = 0;

    instr_sequencer #(
        .RESET_PC   (16'h0010),
        .TIMEOUT_CYC(4)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .MEM_REQ  (MEM_REQ),
        .MEM_WE   (MEM_WE),
        .MEM_ADDR (MEM_ADDR),
        .MEM_ACK  (MEM_ACK),
        .MEM_RDATA(MEM_RDATA),
        .EA       (EA),
        .FLAG_Z   (FLAG_Z),
        .FLAG_S   (FLAG_S),
        .FLAG_V   (FLAG_V),
        .PC       (PC),
        .IR       (IR),
        .MDR      (MDR),
        .S_ALU    (S_ALU),
        .REG_WE   (REG_WE),
        .REG_WSEL (REG_WSEL),
        .FLAG_WE  (FLAG_WE),
        .HALTED   (HALTED),
        .BUS_ERR  (BUS_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    // Serve one instruction fetch; leaves the DUT in DECODE.
    task automatic fetch(input logic [15:0] instr, input int waits, input logic [15:0] addr);
        int n = 0;
        while (MEM_REQ !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("fetch_req", MEM_REQ, 1'b1);
        check("fetch_addr", MEM_ADDR, addr);
        check("fetch_we", MEM_WE, 1'b0);
        repeat (waits) begin
            step();
            check("fetch_hold", MEM_ADDR, addr);
        end
        MEM_RDATA = instr;
        MEM_ACK   = 1'b1;
        step();
        MEM_ACK   = 1'b0;
        check("ir_load", IR, instr);
        check("decode_req", MEM_REQ, 1'b0);
    endtask

    initial begin
        RESET = 1'b1; MEM_ACK = 1'b0; MEM_RDATA = '0; EA = '0;
        FLAG_Z = 1'b0; FLAG_S = 1'b0; FLAG_V = 1'b0;
        step(); step();
        check("rst_pc", PC, 16'h0010);
        check("rst_salu", S_ALU, 4'hF);
        check("rst_req", MEM_REQ, 1'b0);
        check("rst_ir", IR, 16'h0000);
        check("rst_mdr", MDR, 16'h0000);
        check("rst_halt", HALTED, 1'b0);
        check("rst_regwe", REG_WE, 1'b0);
        check("rst_buserr", BUS_ERR, 1'b0);
        RESET = 1'b0;
        step();
        check("first_req", MEM_REQ, 1'b1);
        check("first_addr", MEM_ADDR, 16'h0010);

        // ALU op, zero wait
        fetch(16'hC030, 0, 16'h0010);
        check("alu_pc", PC, 16'h0011);
        check("dec_salu", S_ALU, 4'hF);
        check("dec_regwe", REG_WE, 1'b0);
        step();
        check("exec_salu", S_ALU, 4'h3);
        check("exec_regwe", REG_WE, 1'b1);
        check("exec_flagwe", FLAG_WE, 1'b1);
        check("exec_wsel", REG_WSEL, 2'd0);
        step();
        check("alu_salu_idle", S_ALU, 4'hF);
        check("alu_regwe_off", REG_WE, 1'b0);
        check("alu_next_addr", MEM_ADDR, 16'h0011);

        // LD with two wait cycles
        EA = 16'h0200;
        fetch(16'h0105, 0, 16'h0011);
        step();
        check("ld_req", MEM_REQ, 1'b1);
        check("ld_addr", MEM_ADDR, 16'h0200);
        check("ld_we", MEM_WE, 1'b0);
        repeat (2) begin
            step();
            check("ld_wait_addr", MEM_ADDR, 16'h0200);
            check("ld_wait_regwe", REG_WE, 1'b0);
        end
        MEM_RDATA = 16'hBEEF; MEM_ACK = 1'b1;
        step();
        MEM_ACK = 1'b0;
        check("ld_mdr", MDR, 16'hBEEF);
        check("wb_regwe", REG_WE, 1'b1);
        check("wb_wsel", REG_WSEL, 2'd1);
        check("wb_req", MEM_REQ, 1'b0);
        step();
        check("wb_off", REG_WE, 1'b0);
        check("ld_next_addr", MEM_ADDR, 16'h0012);

        // ST with one fetch wait
        EA = 16'h0300;
        fetch(16'h4000, 1, 16'h0012);
        step();
        check("st_we", MEM_WE, 1'b1);
        check("st_addr", MEM_ADDR, 16'h0300);
        MEM_ACK = 1'b1;
        step();
        MEM_ACK = 1'b0;
        check("st_next_req", MEM_REQ, 1'b1);
        check("st_next_addr", MEM_ADDR, 16'h0013);
        check("st_next_we", MEM_WE, 1'b0);
        check("st_regwe", REG_WE, 1'b0);

        // LI
        fetch(16'h807F, 0, 16'h0013);
        step();
        check("li_regwe", REG_WE, 1'b1);
        check("li_wsel", REG_WSEL, 2'd2);
        check("li_flagwe", FLAG_WE, 1'b0);
        check("li_salu", S_ALU, 4'hF);
        step();
        check("li_next_addr", MEM_ADDR, 16'h0014);

        // B +0x10: 0x0015 + 0x0010
        fetch(16'hA010, 0, 16'h0014);
        step(); step();
        check("b_pc", PC, 16'h0025);
        check("b_addr", MEM_ADDR, 16'h0025);

        // BNE -2, taken then not taken
        FLAG_Z = 1'b0;
        fetch(16'hBBFE, 0, 16'h0025);
        step(); step();
        check("bne_taken_pc", PC, 16'h0024);
        FLAG_Z = 1'b1;
        fetch(16'hBBFE, 0, 16'h0024);
        step(); step();
        check("bne_not_pc", PC, 16'h0025);

        // BLT taken (S^V=1), BLE not taken (Z=0, S^V=0)
        FLAG_Z = 1'b0; FLAG_S = 1'b1; FLAG_V = 1'b0;
        fetch(16'hB904, 0, 16'h0025);
        step(); step();
        check("blt_pc", PC, 16'h002A);
        FLAG_V = 1'b1;
        fetch(16'hBA04, 0, 16'h002A);
        step(); step();
        check("ble_pc", PC, 16'h002B);

        // Unassigned class-10 encoding behaves as NOP
        fetch(16'h8810, 0, 16'h002B);
        step();
        check("nop_regwe", REG_WE, 1'b0);
        step();
        check("nop_pc", PC, 16'h002C);

        // B -0x2E lands on 0xFFFF, then HLT there wraps PC to 0
        fetch(16'hA0D2, 0, 16'h002C);
        step(); step();
        check("far_pc", PC, 16'hFFFF);
        check("far_addr", MEM_ADDR, 16'hFFFF);
        fetch(16'hC0F0, 0, 16'hFFFF);
        check("wrap_pc", PC, 16'h0000);
        step();
        check("halted", HALTED, 1'b1);
        check("halt_req", MEM_REQ, 1'b0);
        MEM_ACK = 1'b1;
        repeat (4) begin
            step();
            check("halt_stay_req", MEM_REQ, 1'b0);
            check("halt_stay", HALTED, 1'b1);
        end
        MEM_ACK = 1'b0;
        check("halt_pc", PC, 16'h0000);

        // Reset out of HALT, then reset mid-fetch with a late ACK
        RESET = 1'b1;
        step();
        check("rh_halted", HALTED, 1'b0);
        check("rh_req", MEM_REQ, 1'b0);
        check("rh_pc", PC, 16'h0010);
        RESET = 1'b0;
        step();
        check("rh_fetch_req", MEM_REQ, 1'b1);
        step(); step();
        RESET = 1'b1;
        step();
        check("mid_req", MEM_REQ, 1'b0);
        RESET = 1'b0; MEM_RDATA = 16'h1234; MEM_ACK = 1'b1;
        step();
        MEM_ACK = 1'b0;
        check("late_ack_ir", IR, 16'h0000);
        check("late_ack_req", MEM_REQ, 1'b1);

`ifdef BUS_TIMEOUT_EN
        repeat (3) step();
        check("to_pre_halt", HALTED, 1'b0);
        check("to_pre_err", BUS_ERR, 1'b0);
        step();
        check("to_err", BUS_ERR, 1'b1);
        check("to_halt", HALTED, 1'b1);
        check("to_req", MEM_REQ, 1'b0);
`else
        repeat (10) step();
        check("noto_err", BUS_ERR, 1'b0);
        check("noto_req", MEM_REQ, 1'b1);
        check("noto_halt", HALTED, 1'b0);
        check("noto_addr", MEM_ADDR, 16'h0010);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
